// File: rtl/and_or_xor_pkg.sv
// Shared op encodings and the per-bit result selector for the bitwise gate unit.
package and_or_xor_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  // Unknown or undriven op resolves to 0 so the selected result never carries X.
  function automatic logic sel_result(input logic [1:0] op, input logic a_and,
                                      input logic a_or, input logic a_xor);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a_and;
      OP_OR:   r = a_or;
      OP_XOR:  r = a_xor;
      OP_XNOR: r = ~a_xor;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/and_or_xor_gate_bit_cell.sv
// One-bit gate cell: the AND/OR/XOR primitives of a single bit position (half-adder carry/sum).
module gate_bit_cell (
  input  logic a,
  input  logic b,
  output logic g_and,
  output logic g_or,
  output logic g_xor
);

  assign g_and = a & b;
  assign g_or  = a | b;
  assign g_xor = a ^ b;

endmodule

// File: rtl/and_or_xor.sv
// Registered bitwise gate unit: AND/OR/XOR of two operands, an op-selected result and parity,
// all produced one clock after the operands are accepted.
module and_or_xor
  import and_or_xor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
  output logic [WIDTH-1:0] y_xor,
  output logic [WIDTH-1:0] y_sel,
  output logic             parity,
  output logic             out_valid
);

  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] xor_w;
  logic [WIDTH-1:0] sel_w;

  // Each bit position is independent: no carry ever crosses between cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gate_bit_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .g_and (and_w[i]),
      .g_or  (or_w[i]),
      .g_xor (xor_w[i])
    );
    assign sel_w[i] = sel_result(op, and_w[i], or_w[i], xor_w[i]);
  end

  // Valid-only handshake (no ready): in_valid=1 at an edge accepts a/b/op, and out_valid is 1
  // for exactly the following cycle. Idle edges drop out_valid but keep the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_and     <= '0;
      y_or      <= '0;
      y_xor     <= '0;
      y_sel     <= '0;
      parity    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_and  <= and_w;
        y_or   <= or_w;
        y_xor  <= xor_w;
        y_sel  <= sel_w;
        parity <= ^xor_w;
      end
    end
  end

endmodule

// File: tb/tb_and_or_xor.sv
// Bench for and_or_xor: directed literal cases, async reset, hold behaviour and a randomized run
// compared every cycle against a word-level behavioural model.
module tb_and_or_xor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic [W-1:0] y_and;
  logic [W-1:0] y_or;
  logic [W-1:0] y_xor;
  logic [W-1:0] y_sel;
  logic         parity;
  logic         out_valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  and_or_xor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .y_and     (y_and),
    .y_or      (y_or),
    .y_xor     (y_xor),
    .y_sel     (y_sel),
    .parity    (parity),
    .out_valid (out_valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Last accepted operands and the one-cycle valid flag; expected outputs derive from these.
  logic [W-1:0] m_a, m_b;
  logic [1:0]   m_op;
  logic         m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_op = 2'b00; m_valid = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_a = a; m_b = b; m_op = op;
      end
    end
  end

  function automatic logic [W-1:0] exp_sel(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x ^ y);
    endcase
  endfunction

  // After reset model a=b=0, op=0 gives all-zero expectations except XNOR, which never
  // appears here because op resets to AND; so the model covers the reset state too.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [W-1:0] ea, eo, ex;
      int ok;
      ea = m_a & m_b;
      eo = m_a | m_b;
      ex = m_a ^ m_b;
      chk("y_and", 32'(y_and), 32'(ea));
      chk("y_or", 32'(y_or), 32'(eo));
      chk("y_xor", 32'(y_xor), 32'(ex));
      chk("y_sel", 32'(y_sel), 32'(exp_sel(m_a, m_b, m_op)));
      chk("parity", 32'(parity), 32'($countones(ex) % 2));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      ok = 1;
      for (int i = 0; i < W; i++)
        if (2 * int'(y_and[i]) + int'(y_xor[i]) != int'(m_a[i]) + int'(m_b[i])) ok = 0;
      chk("half_adder", 32'(ok), 32'd1);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic [1:0] dop,
                       input logic dv);
    @(posedge clk);
    #1;
    a = da; b = db; op = dop; in_valid = dv;
  endtask

  // Checks literal outputs 2 time units after the edge that loads the last driven inputs.
  task automatic lit(input string name, input logic [W-1:0] ea, input logic [W-1:0] eo,
                     input logic [W-1:0] ex, input logic [W-1:0] es, input logic ep,
                     input logic ev);
    @(posedge clk);
    #2;
    chk({name, "_and"}, 32'(y_and), 32'(ea));
    chk({name, "_or"}, 32'(y_or), 32'(eo));
    chk({name, "_xor"}, 32'(y_xor), 32'(ex));
    chk({name, "_sel"}, 32'(y_sel), 32'(es));
    chk({name, "_par"}, 32'(parity), 32'(ep));
    chk({name, "_vld"}, 32'(out_valid), 32'(ev));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y_or", 32'(y_or), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_en = 1;

    drive(8'd29, 8'd5, 2'b00, 1'b1);
    lit("t1", 8'h05, 8'h1D, 8'h18, 8'h05, 1'b0, 1'b1);
    drive(8'd51, 8'd92, 2'b01, 1'b1);
    lit("t2", 8'h10, 8'h7F, 8'h6F, 8'h7F, 1'b0, 1'b1);
    drive(8'd78, 8'd255, 2'b11, 1'b1);
    lit("t3", 8'h4E, 8'hFF, 8'hB1, 8'h4E, 1'b0, 1'b1);

    // Hold: one load then three idle cycles with junk operands.
    drive(8'hF0, 8'h0F, 2'b10, 1'b1);
    lit("hold_ld", 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), W'($urandom), 2'($urandom), 1'b0);
      lit("hold", 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    end

    // Async reset while out_valid is high: outputs must clear before the next edge.
    drive(8'hA5, 8'h3C, 2'b11, 1'b1);
    @(posedge clk);
    #2;
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_and", 32'(y_and), 32'd0);
    chk("arst_or", 32'(y_or), 32'd0);
    chk("arst_xor", 32'(y_xor), 32'd0);
    chk("arst_sel", 32'(y_sel), 32'd0);
    chk("arst_par", 32'(parity), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // First accepting edge after release loads without a warm-up cycle.
    drive(8'hFF, 8'h01, 2'b10, 1'b1);
    lit("rel", 8'h01, 8'hFF, 8'hFE, 8'hFE, 1'b1, 1'b1);

    // Randomized run; the per-cycle compare process does the checking.
    for (int i = 0; i < 1000; i++)
      drive(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0));
    drive('0, '0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
